alu_seq_param: RTL and testbench
================================

ALU_SEQ_PARAM -- requirements
Module: alu_seq_param

Interface
REQ-001 Parameter W, default 8, operand/data-bus width in bits; legal range 4..32.
REQ-002 CLk  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 Begin  input  1  start request; sampled only in IDLE.
REQ-005 op  input  2  operation: 0 add, 1 sub, 2 signed multiply, 3 unsigned divide; sampled with Begin.
REQ-006 inbus  input  W  operand bus: A on the Begin edge, B on the following edge.
REQ-007 outbus  output  W  registered result word.
REQ-008 valid  output  1  high for each cycle outbus carries a new result word.
REQ-009 busy  output  1  high from the edge after Begin is accepted until return to IDLE.
REQ-010 ovf  output  1  add/sub signed overflow; divide-by-zero for op 3; held with results.

Function
REQ-011 The FSM SHALL have states IDLE, LOAD_B, ADDSUB, MUL, DIV, OUT1 and OUT2.
REQ-012 Edge E0, IDLE with Begin=1: latch op and A=inbus, go to LOAD_B; Begin=0 stays in IDLE.
REQ-013 E1 (LOAD_B): latch B=inbus; next state ADDSUB (op 0/1), MUL (op 2) or DIV (op 3).
REQ-014 ADDSUB SHALL take 1 cycle: R=A+B or A-B mod 2^W; ovf = two's-complement overflow.
REQ-015 MUL SHALL use radix-2 Booth over exactly W cycles, giving a 2W-bit signed product.
REQ-016 DIV SHALL use restoring/non-restoring division over exactly W cycles, giving W-bit unsigned quotient Q and remainder Rm.
REQ-017 B=0 in DIV: Q all ones, Rm=A, ovf=1; cycle count unchanged.
REQ-018 OUT1 edge: outbus=R (add/sub), product low word (mul) or Q (div); valid=1.
REQ-019 Mul/div SHALL pass through OUT2 on the next edge: outbus = product high word or Rm; valid=1.
REQ-020 Add/sub SHALL return to IDLE after OUT1; mul/div after OUT2.
REQ-021 Latency from E0 to the first valid word: 3 edges for add/sub; W+2 edges for mul/div.
REQ-022 valid SHALL be 0 in every cycle other than the result-word cycles.
REQ-023 outbus and ovf SHALL hold the last value until the next result word or reset.
REQ-024 Begin outside IDLE SHALL be ignored, including during OUT1/OUT2.
REQ-025 A new Begin is accepted on the first edge the FSM is back in IDLE.
REQ-026 inbus is don't-care outside E0 and E1.
REQ-027 op changes after E0 SHALL have no effect on the running operation.

Reset
REQ-028 RST=1 on an edge SHALL force IDLE and clear outbus, valid, busy, ovf and all internal registers to 0, overriding Begin.
REQ-029 RST asserted mid-operation SHALL abort it; no valid pulse follows.
REQ-030 After RST deasserts, Begin is accepted on the next edge.

Verification (W=8)
REQ-031 add 24+31 -> outbus=55, ovf=0, valid 1 cycle, 3 edges after E0; then sub 99-55 -> 44.
REQ-032 add 127+1 -> outbus=0x80, ovf=1; sub 0x80-1 -> 0x7F, ovf=1.
REQ-033 mul 32*25 -> 0x20 then 0x03; mul -3*5 (0xFD,0x05) -> 0xF1 then 0xFF; first word 10 edges after E0.
REQ-034 div 100/7 -> Q=14 then Rm=2, ovf=0; div 9/0 -> Q=0xFF, Rm=9, ovf=1.
REQ-035 Begin held high through a mul -> exactly one operation runs; next accepted only in IDLE.
REQ-036 RST pulsed 4 cycles into a mul -> all outputs 0, no valid pulse; following add 5+6 -> 11.

Source files
------------

// File: rtl/alu_seq_param.sv
// Sequential two-operand ALU with a single shared operand bus.
//
// A start request in idle latches the opcode and operand A; operand B follows on the next
// edge. Add/sub completes in one cycle; signed multiply (radix-2 Booth) and unsigned
// divide (restoring) each take exactly W cycles. Results are returned as one word
// (add/sub) or two consecutive words (mul: low/high product, div: quotient/remainder).
//
// Ports:
//   CLk    - clock, all state updates on the rising edge
//   RST    - synchronous active-high reset
//   Begin  - start request, honoured only in idle
//   op     - 0 add, 1 sub, 2 signed multiply, 3 unsigned divide
//   inbus  - operand bus (A on the start edge, B on the next edge)
//   outbus - registered result word, held until the next result or reset
//   valid  - high for each cycle outbus carries a new result word
//   busy   - high while an operation is in flight
//   ovf    - signed overflow for add/sub, divide-by-zero for divide
module alu_seq_param #(
  parameter int unsigned W = 8
) (
  input  logic         CLk,
  input  logic         RST,
  input  logic         Begin,
  input  logic [1:0]   op,
  input  logic [W-1:0] inbus,
  output logic [W-1:0] outbus,
  output logic         valid,
  output logic         busy,
  output logic         ovf
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StLoadB,
    StAddSub,
    StMul,
    StDiv,
    StOut1,
    StOut2
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  // hi holds the Booth partial product / the division remainder (one guard bit).
  // lo holds the multiplier / the dividend-then-quotient, or the add/sub result.
  logic [W:0]    hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic          q1_q, q1_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flag_q, flag_d;
  logic [W-1:0]  outbus_q, outbus_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;

  logic [W-1:0]  sum_w;
  logic          addsub_ovf;
  logic [W:0]    m_ext;
  logic [W:0]    booth_sum;
  logic [W:0]    rem_shift;
  logic [W:0]    rem_diff;

  always_comb begin
    // op_q[0] distinguishes sub from add
    sum_w = op_q[0] ? (a_q - b_q) : (a_q + b_q);
    if (op_q[0]) begin
      addsub_ovf = (a_q[W-1] != b_q[W-1]) && (sum_w[W-1] != a_q[W-1]);
    end else begin
      addsub_ovf = (a_q[W-1] == b_q[W-1]) && (sum_w[W-1] != a_q[W-1]);
    end

    m_ext = {a_q[W-1], a_q};
    case ({lo_q[0], q1_q})
      2'b01:   booth_sum = hi_q + m_ext;
      2'b10:   booth_sum = hi_q - m_ext;
      default: booth_sum = hi_q;
    endcase

    rem_shift = {hi_q[W-1:0], lo_q[W-1]};
    rem_diff  = rem_shift - {1'b0, b_q};
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    q1_d     = q1_q;
    cnt_d    = cnt_q;
    flag_d   = flag_q;
    outbus_d = outbus_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (Begin) begin
          op_d    = op;
          a_d     = inbus;
          busy_d  = 1'b1;
          state_d = StLoadB;
        end
      end
      StLoadB: begin
        b_d    = inbus;
        cnt_d  = '0;
        hi_d   = '0;
        q1_d   = 1'b0;
        flag_d = 1'b0;
        case (op_q)
          2'd2: begin
            lo_d    = inbus;
            state_d = StMul;
          end
          2'd3: begin
            lo_d    = a_q;
            // A zero divisor falls out of the restoring loop as Q = all ones, Rm = A
            flag_d  = (inbus == '0);
            state_d = StDiv;
          end
          default: state_d = StAddSub;
        endcase
      end
      StAddSub: begin
        lo_d    = sum_w;
        flag_d  = addsub_ovf;
        state_d = StOut1;
      end
      StMul: begin
        // Arithmetic right shift of {hi, lo, q1} after the Booth add/subtract
        hi_d  = {booth_sum[W], booth_sum[W:1]};
        lo_d  = {booth_sum[0], lo_q[W-1:1]};
        q1_d  = lo_q[0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d = StOut1;
        end
      end
      StDiv: begin
        if (!rem_diff[W]) begin
          hi_d = rem_diff;
          lo_d = {lo_q[W-2:0], 1'b1};
        end else begin
          hi_d = rem_shift;
          lo_d = {lo_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d = StOut1;
        end
      end
      StOut1: begin
        outbus_d = lo_q;
        ovf_d    = flag_q;
        valid_d  = 1'b1;
        if (op_q[1]) begin
          state_d = StOut2;
        end else begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      StOut2: begin
        outbus_d = hi_q[W-1:0];
        valid_d  = 1'b1;
        busy_d   = 1'b0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLk) begin
    if (RST) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      q1_q     <= 1'b0;
      cnt_q    <= '0;
      flag_q   <= 1'b0;
      outbus_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      q1_q     <= q1_d;
      cnt_q    <= cnt_d;
      flag_q   <= flag_d;
      outbus_q <= outbus_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
    end
  end

  assign outbus = outbus_q;
  assign valid  = valid_q;
  assign busy   = busy_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_alu_seq_param.sv
// Directed bench for alu_seq_param (W=8). Expected result words come from an integer
// model and are queued when an operation is driven; they are popped as valid words appear.
module tb_alu_seq_param;

  localparam int W = 8;

  logic         CLk;
  logic         RST;
  logic         Begin;
  logic [1:0]   op;
  logic [W-1:0] inbus;
  logic [W-1:0] outbus;
  logic         valid;
  logic         busy;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  // {ovf, word}
  logic [W:0] exp_q[$];
  logic [W:0] last_exp;

  alu_seq_param #(.W(W)) dut (
    .CLk    (CLk),
    .RST    (RST),
    .Begin  (Begin),
    .op     (op),
    .inbus  (inbus),
    .outbus (outbus),
    .valid  (valid),
    .busy   (busy),
    .ovf    (ovf)
  );

  initial CLk = 1'b0;
  always #5 CLk = ~CLk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ovf_of(input int r);
    int lim;
    lim = 1 << (W - 1);
    return (r >= lim) || (r < -lim);
  endfunction

  task automatic model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb, r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      2'd0: begin
        r = sa + sb;
        exp_q.push_back({ovf_of(r), r[W-1:0]});
      end
      2'd1: begin
        r = sa - sb;
        exp_q.push_back({ovf_of(r), r[W-1:0]});
      end
      2'd2: begin
        p = 64'(longint'(sa) * longint'(sb));
        exp_q.push_back({1'b0, p[W-1:0]});
        exp_q.push_back({1'b0, p[2*W-1:W]});
      end
      default: begin
        if (b == '0) begin
          exp_q.push_back({1'b1, {W{1'b1}}});
          exp_q.push_back({1'b1, a});
        end else begin
          exp_q.push_back({1'b0, a / b});
          exp_q.push_back({1'b0, a % b});
        end
      end
    endcase
  endtask

  task automatic pop_chk(input string tag);
    logic [W:0] e;
    chk({tag, "_queue"}, 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      last_exp = e;
      chk({tag, "_word"}, 64'(outbus), 64'(e[W-1:0]));
      chk({tag, "_ovf"}, 64'(ovf), 64'(e[W]));
    end
  endtask

  // Drives one operation, then watches a fixed window of edges for its result words.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string tag);
    int lat, nw, seen, first;
    model(o, a, b);
    lat = (o < 2) ? 3 : W + 2;
    nw  = (o < 2) ? 1 : 2;
    Begin = 1'b1;
    op    = o;
    inbus = a;
    @(posedge CLk); #1;
    Begin = 1'b0;
    op    = ~o;
    inbus = b;
    seen  = 0;
    first = -1;
    for (int e = 1; e <= W + 6; e++) begin
      @(posedge CLk); #1;
      if (e == 1) begin
        inbus = W'($urandom);
        chk({tag, "_busy_run"}, 64'(busy), 64'd1);
      end
      if (valid) begin
        if (first < 0) first = e;
        seen++;
        pop_chk(tag);
      end
    end
    chk({tag, "_latency"}, 64'(first), 64'(lat));
    chk({tag, "_nwords"}, 64'(seen), 64'(nw));
    chk({tag, "_busy_done"}, 64'(busy), 64'd0);
    chk({tag, "_hold"}, 64'(outbus), 64'(last_exp[W-1:0]));
  endtask

  initial begin
    int seen, first;
    RST   = 1'b1;
    Begin = 1'b1;
    op    = 2'd2;
    inbus = 8'hA5;
    last_exp = '0;
    repeat (2) @(posedge CLk);
    #1;
    chk("rst_outbus", 64'(outbus), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    RST   = 1'b0;
    Begin = 1'b0;

    // Idle with Begin low must not start anything
    repeat (3) @(posedge CLk);
    #1;
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_valid", 64'(valid), 64'd0);

    run_op(2'd0, 8'd24, 8'd31, "add_24_31");
    run_op(2'd1, 8'd99, 8'd55, "sub_99_55");
    run_op(2'd0, 8'd127, 8'd1, "add_ovf");
    run_op(2'd1, 8'h80, 8'd1, "sub_ovf");
    run_op(2'd2, 8'd32, 8'd25, "mul_32_25");
    run_op(2'd2, 8'hFD, 8'h05, "mul_m3_5");
    run_op(2'd2, 8'h80, 8'h80, "mul_min_min");
    run_op(2'd2, 8'h7F, 8'hFF, "mul_max_m1");
    run_op(2'd3, 8'd100, 8'd7, "div_100_7");
    run_op(2'd3, 8'hFF, 8'h01, "div_ff_1");
    run_op(2'd3, 8'd5, 8'd200, "div_small");
    for (int i = 0; i < 4; i++) begin
      run_op(2'($urandom_range(0, 3)), W'($urandom), W'($urandom), "rand");
    end

    // Begin held high through a whole mul: exactly one operation may run
    model(2'd2, 8'h7F, 8'h80);
    Begin = 1'b1;
    op    = 2'd2;
    inbus = 8'h7F;
    @(posedge CLk); #1;
    inbus = 8'h80;
    op    = 2'd0;
    seen  = 0;
    first = -1;
    for (int e = 1; e <= W + 3; e++) begin
      @(posedge CLk); #1;
      if (e == 1) inbus = 8'h33;
      if (valid) begin
        if (first < 0) first = e;
        seen++;
        pop_chk("held_mul");
      end
    end
    Begin = 1'b0;
    for (int e = 1; e <= W + 6; e++) begin
      @(posedge CLk); #1;
      if (valid) seen++;
    end
    chk("held_latency", 64'(first), 64'(W + 2));
    chk("held_nwords", 64'(seen), 64'd2);
    chk("held_busy", 64'(busy), 64'd0);

    // Leave ovf set so the reset below has something to clear
    run_op(2'd3, 8'd9, 8'd0, "div_by_zero");

    // Reset four cycles into a mul aborts it
    Begin = 1'b1;
    op    = 2'd2;
    inbus = 8'h13;
    @(posedge CLk); #1;
    Begin = 1'b0;
    inbus = 8'h17;
    repeat (4) @(posedge CLk);
    #1;
    RST = 1'b1;
    @(posedge CLk); #1;
    RST = 1'b0;
    chk("abort_outbus", 64'(outbus), 64'd0);
    chk("abort_valid", 64'(valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ovf", 64'(ovf), 64'd0);
    run_op(2'd0, 8'd5, 8'd6, "add_after_rst");

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
